uart_word_assembler: RTL
========================

# uart_word_assembler

- Sits directly downstream of the UART receiver in the monitor's load path.
- Consumes the receiver's byte pulses (`data_valid`/`data_out`) and its end-of-block pulse (`block_timeout`).
- Packs bytes little-endian into 32-bit words and emits each word with a sequential word address, ready for a memory-write port.
- Pads and flushes a trailing partial word when the block ends, then signals block completion.

## Interface
- `ADDR_W`, 10, word-address width; addresses wrap modulo 2^ADDR_W.
- `START_ADDR`, 0, word address of the first word of every block.

- `clk`  in  1  system clock (27 MHz).
- `rst`  in  1  asynchronous, active-low reset.
- `byte_valid`  in  1  one-cycle pulse, byte available (receiver `data_valid`).
- `byte_in`  in  8  received byte (receiver `data_out`).
- `block_timeout`  in  1  one-cycle pulse, line idle / end of block.
- `word_valid`  out  1  one-cycle pulse, `word_data`/`word_addr` valid.
- `word_data`  out  32  assembled word; first byte of the group in [7:0].
- `word_addr`  out  ADDR_W  address of the word on `word_data`.
- `partial`  out  1  pulses with `word_valid` when the word was zero-padded.
- `block_done`  out  1  one-cycle pulse, block finished.
- `word_cnt`  out  ADDR_W+1  words emitted in current/last block; held until next block's first byte.
- `checksum`  out  8  see Configuration.

## Operation
- **Reset values:**
  - All outputs 0, except `word_addr` = START_ADDR.
  - State IDLE, byte index 0.
- **States:** IDLE, COLLECT, FLUSH, DONE.
- **IDLE:**
  - `byte_valid` clears `word_cnt` and `checksum`.
  - The byte is stored in lane 0, index ← 1, state → COLLECT.
  - `block_timeout` in IDLE is ignored: empty block, no `block_done`.
- **COLLECT:**
  - Each `byte_valid` stores `byte_in` in lane [index], index ← index+1 (mod 4).
  - When the 4th lane is written:
    - `word_valid` pulses with the full word at the current address.
    - The address increments (wraps at 2^ADDR_W to 0) and `word_cnt` increments.
- **COLLECT + `block_timeout`:**
  - index ≠ 0 → FLUSH.
  - index = 0 → DONE.
- **FLUSH:**
  - Unfilled lanes are forced to 0x00.
  - `word_valid` and `partial` pulse, `word_cnt` increments, state → DONE.
- **DONE:**
  - `block_done` pulses.
  - Address reloads START_ADDR, index ← 0, state → IDLE.
- **Simultaneous `byte_valid` and `block_timeout` in COLLECT:**
  - The byte is stored first; the timeout then applies to the updated index.
  - Example: the 4th byte plus the timeout emits the full word, then DONE.
- `byte_valid` during FLUSH or DONE is dropped. The receiver cannot produce one within 86 cycles of a timeout.
- `word_data` and `word_addr` hold their last values between pulses.
- Reset asserted mid-block discards all partial state immediately, with no `word_valid` or `block_done`.

## Timing
- `word_valid` is registered: it asserts on the cycle after the clock edge that captured the 4th byte.
- Timeout with partial word:
  - `word_valid` + `partial` one cycle after the timeout.
  - `block_done` two cycles after the timeout.
- Timeout word-aligned: `block_done` one cycle after the timeout.
- No backpressure: the consumer must accept a `word_valid` pulse every cycle it is asserted.
- Minimum spacing is 4 bytes, i.e. ≥ 344 cycles at 3 Mbaud.
- Throughput is bounded only by the byte rate.

## Configuration
- `UART_WORD_ASM_CKSUM_EN` defined:
  - `checksum` is the mod-256 sum of all received bytes of the current block, excluding padding.
  - It updates the cycle after each byte, is cleared on a block's first byte, and is final when `block_done` pulses.
- `UART_WORD_ASM_CKSUM_EN` not defined:
  - `checksum` is tied to 8'h00.
  - No adder logic is synthesised.

## Test plan
- **Aligned block:**
  - Stimulus: bytes 11,22,33,44,55,66,77,88, then timeout.
  - Response: words 0x44332211 @0 and 0x88776655 @1 with `partial`=0.
  - Then `block_done` one cycle after the timeout, `word_cnt`=2.
- **Partial flush:**
  - Stimulus: bytes AA,BB,CC, then timeout.
  - Response: `word_valid`+`partial` with 0x00CCBBAA @0 at T+1, `block_done` at T+2.
  - With CKSUM_EN: `checksum`=0x31.
- **Empty / post-reset timeout:**
  - Stimulus: timeout with no bytes.
  - Response: no `word_valid`, no `block_done`.
- **Simultaneous:**
  - Stimulus: 4th byte (0xDE) and timeout in the same cycle after 01,02,03.
  - Response: 0xDE030201 @0 with `partial`=0, then `block_done`.
- **Wrap:**
  - Stimulus: ADDR_W=2, 5 words.
  - Response: addresses 0,1,2,3,0.
  - Next block starts at START_ADDR.
- **Reset mid-block:**
  - Stimulus: 2 bytes, reset pulse, then 4 bytes 01..04.
  - Response: a single word 0x04030201 @START_ADDR.

Source files
------------

// File: rtl/uart_word_assembler.sv
// uart_word_assembler
// Packs UART receiver bytes little-endian into 32-bit words with sequential
// word addresses for a memory-write port. A trailing partial word is
// zero-padded and flushed on block timeout, followed by a block_done pulse.
// Optional feature: define UART_WORD_ASM_CKSUM_EN to enable a mod-256
// checksum of the block's received bytes; otherwise checksum is tied to 0.
module uart_word_assembler #(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,           // asynchronous, active-low
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  input  logic              block_timeout,
  output logic              word_valid,
  output logic [31:0]       word_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic              partial,
  output logic              block_done,
  output logic [ADDR_W:0]   word_cnt,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  state_t            state_reg;
  logic [1:0]        idx_reg;
  logic [3:0][7:0]   lane_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic              accept;
  logic [1:0]        idx_next;
  logic [3:0][7:0]   lane_next;
  logic [31:0]       pad_word;
  logic              full_word;
  logic              flush_now;
  logic [ADDR_W:0]   cnt_base;

  // Bytes are only taken while a block is being collected (or starting).
  assign accept    = byte_valid && ((state_reg == IDLE) || (state_reg == COLLECT));
  assign idx_next  = accept ? (idx_reg + 2'd1) : idx_reg;
  assign full_word = accept && (idx_reg == 2'd3);
  // Timeout is evaluated against the index after any same-cycle byte store.
  assign flush_now = block_timeout && ((state_reg == COLLECT) || accept) && (idx_next != 2'd0);
  // A first byte in IDLE restarts the word count for the new block.
  assign cnt_base  = (state_reg == IDLE) ? '0 : word_cnt;

  // Lane image including the byte arriving this cycle, and its zero-padded form.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_next[gi]       = (accept && (idx_reg == 2'(gi))) ? byte_in : lane_reg[gi];
    assign pad_word[gi*8 +: 8] = (2'(gi) < idx_next) ? lane_next[gi] : 8'h00;
  end

  // Control FSM; outputs are registered on state entry so the flush word
  // appears one cycle after the timeout and block_done the cycle after that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      idx_reg    <= 2'd0;
      lane_reg   <= '0;
      addr_reg   <= START_ADDR;
      word_valid <= 1'b0;
      word_data  <= 32'h0;
      word_addr  <= START_ADDR;
      partial    <= 1'b0;
      block_done <= 1'b0;
      word_cnt   <= '0;
    end else begin
      word_valid <= 1'b0;
      partial    <= 1'b0;
      block_done <= 1'b0;
      case (state_reg)
        IDLE, COLLECT: begin
          if (accept) begin
            lane_reg <= lane_next;
            idx_reg  <= idx_next;
          end
          if (full_word || flush_now) begin
            word_valid <= 1'b1;
            partial    <= flush_now;
            word_data  <= full_word ? lane_next : pad_word;
            word_addr  <= addr_reg;
            addr_reg   <= addr_reg + ADDR_W'(1);
            word_cnt   <= cnt_base + (ADDR_W+1)'(1);
          end else if (accept && (state_reg == IDLE)) begin
            word_cnt <= '0;
          end
          if (flush_now) begin
            state_reg <= FLUSH;
          end else if (block_timeout && ((state_reg == COLLECT) || accept)) begin
            state_reg  <= DONE;
            block_done <= 1'b1;
          end else if (accept) begin
            state_reg <= COLLECT;
          end
        end
        FLUSH: begin
          state_reg  <= DONE;
          block_done <= 1'b1;
        end
        DONE: begin
          addr_reg  <= START_ADDR;
          idx_reg   <= 2'd0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef UART_WORD_ASM_CKSUM_EN
  logic [7:0] cksum_reg;

  // Running mod-256 sum of the block's bytes, restarted on the first byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cksum_reg <= 8'h00;
    end else if (accept) begin
      cksum_reg <= (state_reg == IDLE) ? byte_in : (cksum_reg + byte_in);
    end
  end

  assign checksum = cksum_reg;
`else
  assign checksum = 8'h00;
`endif

endmodule
